// File: rtl/pmem_loader_pkg.sv
// pmem_loader_pkg: shared types and constants for the UART program-memory
// boot loader.
//   ld_state_t : load FSM states (S_CSUM exists only with
//                PMEM_LOADER_CHECKSUM_EN defined)
//   rx_state_t : UART receiver bit-phase states
//   SYNC_BYTE  : frame start marker
//   BYTES_PER_WORD : bytes per PMEM word
package pmem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef PMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/pmem_loader_uart_rx.sv
// pmem_loader_uart_rx: 8N1 UART receiver.
//   clk, c_sys_rst_n : clock, async active-low reset
//   uart_rx          : raw serial input (idle high), synchronised here
//   byte_valid       : 1-cycle pulse, rx_byte holds the received byte
//   rx_byte          : last good byte
//   frame_err        : 1-cycle pulse when the stop bit samples low
module pmem_loader_uart_rx
    import pmem_loader_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       c_sys_rst_n,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int                CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLK_DIV - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_t        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             bv_q, bv_d, fe_q, fe_d;

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                // only a high->low transition starts a frame, so a line
                // stuck low after a bad stop bit does not retrigger
                if (prev_q && !sync2_q) st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    st_d  = RX_IDLE;
                    if (sync2_q) begin
                        bv_d   = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge c_sys_rst_n) begin
        if (!c_sys_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
        end
    end

    assign byte_valid = bv_q;
    assign rx_byte    = byte_q;
    assign frame_err  = fe_q;

endmodule

// File: rtl/pmem_loader.sv
// pmem_loader: UART boot loader feeding the PMEM write port (ic1).
// Frame: A5, LEN lo, LEN hi, LEN*4 little-endian data bytes
// [, XOR checksum byte when PMEM_LOADER_CHECKSUM_EN is defined].
//   clk, c_sys_rst_n          : clock, async active-low reset
//   uart_rx                   : serial input, idle high
//   ic1_c_axi_mst_wr_valid    : 1-cycle write strobe per word
//   ic1_axi_mst_wr_data/addr  : write data / byte address (held between strobes)
//   c_core_rst                : CPU reset, released only on successful load
//   c_load_done / c_load_err  : load status
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int          CLK_DIV   = 868,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        c_sys_rst_n,
    input  logic        uart_rx,
    output logic        ic1_c_axi_mst_wr_valid,
    output logic [31:0] ic1_axi_mst_wr_data,
    output logic [31:0] ic1_axi_mst_wr_addr,
    output logic        c_core_rst,
    output logic        c_load_done,
    output logic        c_load_err
);

    localparam logic [16:0] MAX_W     = 17'(MAX_WORDS);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);
`ifdef PMEM_LOADER_CHECKSUM_EN
    localparam ld_state_t   S_FIN     = S_CSUM;
`else
    localparam ld_state_t   S_FIN     = S_DONE;
`endif

    logic       byte_valid, frame_err;
    logic [7:0] rx_byte;

    pmem_loader_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk        (clk),
        .c_sys_rst_n(c_sys_rst_n),
        .uart_rx    (uart_rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    ld_state_t   state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic        wr_valid_q, wr_valid_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] wr_addr_q, wr_addr_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic sync_hit;
    assign sync_hit = byte_valid && (rx_byte == SYNC_BYTE);

    // state register
    always_ff @(posedge clk or negedge c_sys_rst_n) begin
        if (!c_sys_rst_n) state_q <= S_SYNC;
        else              state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SYNC: if (sync_hit) state_d = S_LEN0;
            S_LEN0: begin
                if (frame_err)       state_d = S_ERR;
                else if (byte_valid) state_d = S_LEN1;
            end
            S_LEN1: begin
                if (frame_err) state_d = S_ERR;
                else if (byte_valid) begin
                    if ({1'b0, rx_byte, len_lo_q} > MAX_W) state_d = S_ERR;
                    else if ({rx_byte, len_lo_q} == 16'd0) state_d = S_FIN;
                    else                                   state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (frame_err) state_d = S_ERR;
                else if (byte_valid && byte_cnt_q == LAST_BYTE &&
                         word_idx_q == len_q - 16'd1)
                    state_d = S_FIN;
            end
`ifdef PMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (frame_err) state_d = S_ERR;
                else if (byte_valid) state_d = (rx_byte == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: if (sync_hit) state_d = S_LEN0;
            default: state_d = S_SYNC;
        endcase
    end

    // status outputs straight from the state register, so core reset
    // release and done rise on the same edge
    always_comb begin
        c_core_rst  = (state_q != S_DONE);
        c_load_done = (state_q == S_DONE);
        c_load_err  = (state_q == S_ERR);
    end

    // word assembly, address generation, checksum
    always_comb begin
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        wr_valid_d = 1'b0;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
`ifdef PMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (byte_valid) begin
            case (state_q)
                S_SYNC, S_DONE, S_ERR: begin
                    // restart clears any word left half-built by an error
                    if (rx_byte == SYNC_BYTE) begin
                        word_d     = '0;
                        byte_cnt_d = '0;
                        word_idx_d = '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
                        csum_d     = '0;
`endif
                    end
                end
                S_LEN0: len_lo_d = rx_byte;
                S_LEN1: len_d    = {rx_byte, len_lo_q};
                S_DATA: begin
                    word_d     = {rx_byte, word_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef PMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_byte;
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = {rx_byte, word_q};
                        wr_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                        word_idx_d = word_idx_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge c_sys_rst_n) begin
        if (!c_sys_rst_n) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign ic1_c_axi_mst_wr_valid = wr_valid_q;
    assign ic1_axi_mst_wr_data    = wr_data_q;
    assign ic1_axi_mst_wr_addr    = wr_addr_q;

endmodule

// File: tb/tb_pmem_loader.sv
// tb_pmem_loader: bench for pmem_loader (CLK_DIV=4). A frame-level parser
// model predicts the write list and final status for each byte stream.
// Honours PMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_pmem_loader;

    localparam int          CLK_DIV   = 4;
    localparam int          MAX_WORDS = 4096;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [7:0]  SYNC      = 8'hA5;
    localparam int ST_IDLE = 0, ST_DONE = 1, ST_ERR = 2;

    logic        clk = 1'b0;
    logic        c_sys_rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        wr_valid;
    logic [31:0] wr_data, wr_addr;
    logic        c_core_rst, c_load_done, c_load_err;

    pmem_loader #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS)) dut (
        .clk                   (clk),
        .c_sys_rst_n           (c_sys_rst_n),
        .uart_rx               (uart_rx),
        .ic1_c_axi_mst_wr_valid(wr_valid),
        .ic1_axi_mst_wr_data   (wr_data),
        .ic1_axi_mst_wr_addr   (wr_addr),
        .c_core_rst            (c_core_rst),
        .c_load_done           (c_load_done),
        .c_load_err            (c_load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  s_b[$];
    bit          s_bad[$];
    logic [63:0] m_wr[$];
    logic [63:0] got_wr[$];
    int          m_st = ST_IDLE;
    int          viol = 0;
    logic        prev_wv = 1'b0;

    // write capture plus cycle-level invariants: one-cycle strobes,
    // core reset always the inverse of done, never done and err together
    always @(negedge clk) begin
        if (c_sys_rst_n) begin
            if (wr_valid) got_wr.push_back({wr_addr, wr_data});
            if (wr_valid && prev_wv) viol++;
            if (c_core_rst !== ~c_load_done) viol++;
            if (c_load_done && c_load_err) viol++;
            prev_wv = wr_valid;
        end else begin
            prev_wv = 1'b0;
        end
    end

    function automatic logic [2:0] exp_stat(int st);
        case (st)
            ST_DONE: return 3'b010;
            ST_ERR:  return 3'b101;
            default: return 3'b100;
        endcase
    endfunction

    task automatic add(input logic [7:0] b, input bit bad = 1'b0);
        s_b.push_back(b);
        s_bad.push_back(bad);
    endtask

    task automatic add_csum(input logic [7:0] v);
`ifdef PMEM_LOADER_CHECKSUM_EN
        add(v);
`else
        if (v === 8'hxx) add(v);
`endif
    endtask

    task automatic add_img1();
        add(8'hA5); add(8'h02); add(8'h00);
        add(8'h78); add(8'h56); add(8'h34); add(8'h12);
        add(8'hEF); add(8'hBE); add(8'hAD); add(8'hDE);
    endtask

    // Frame-level parser: hunt for a clean A5, read LEN, collect words,
    // then (optionally) compare the XOR of the data bytes.
    task automatic run_model();
        int n, i, len;
        bit fail;
        logic [31:0] w;
        logic [7:0]  x;
        n = s_b.size();
        i = 0;
        while (i < n) begin
            if (s_bad[i] || s_b[i] != SYNC) begin i++; continue; end
            i++;
            m_st = ST_IDLE;
            x    = 8'h00;
            fail = 1'b0;
            if (s_bad[i])   begin m_st = ST_ERR; i += 1; continue; end
            if (s_bad[i+1]) begin m_st = ST_ERR; i += 2; continue; end
            len = int'({s_b[i+1], s_b[i]});
            i += 2;
            if (len > MAX_WORDS) begin m_st = ST_ERR; continue; end
            for (int wi = 0; wi < len && !fail; wi++) begin
                w = '0;
                for (int k = 0; k < 4 && !fail; k++) begin
                    if (s_bad[i]) fail = 1'b1;
                    else begin w[8*k +: 8] = s_b[i]; x ^= s_b[i]; end
                    i++;
                end
                if (!fail) m_wr.push_back({BASE + 32'(4 * wi), w});
            end
            if (fail) begin m_st = ST_ERR; continue; end
`ifdef PMEM_LOADER_CHECKSUM_EN
            m_st = (s_bad[i] || s_b[i] != x) ? ST_ERR : ST_DONE;
            i++;
`else
            m_st = ST_DONE;
`endif
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(b[k]);
        send_bit(bad ? 1'b0 : 1'b1);
        repeat ($urandom_range(1, 3)) send_bit(1'b1);
    endtask

    task automatic send_glitch();
        uart_rx = 1'b0;
        @(posedge clk); #1;
        uart_rx = 1'b1;
        repeat (3) send_bit(1'b1);
    endtask

    task automatic run_stream();
        run_model();
        foreach (s_b[k]) send_byte(s_b[k], s_bad[k]);
        repeat (20 * CLK_DIV) @(posedge clk);
        @(negedge clk); #1;
        s_b.delete();
        s_bad.delete();
    endtask

    task automatic do_reset();
        c_sys_rst_n = 1'b0;
        uart_rx     = 1'b1;
        repeat (3) @(posedge clk);
        #1 c_sys_rst_n = 1'b1;
        got_wr.delete();
        m_wr.delete();
        m_st = ST_IDLE;
        viol = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (8 * CLK_DIV) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({wr_valid, wr_data, wr_addr, c_core_rst, c_load_done, c_load_err} !== {1'b0, 64'h0, 3'b100}) begin
            errors++;
            $display("FAIL reset_vals: got v=%b d=%h a=%h rst/done/err=%b%b%b required 0 0 0 100",
                     wr_valid, wr_data, wr_addr, c_core_rst, c_load_done, c_load_err);
        end
        checks++;
        if (got_wr.size() != 0) begin
            errors++;
            $display("FAIL reset_nowr: got %0d writes required 0", got_wr.size());
        end
    endtask

    task automatic test_basic();
        do_reset();
        add_img1();
        add_csum(8'h2A);
        run_stream();
        checks++;
        if (got_wr.size() != m_wr.size()) begin
            errors++;
            $display("FAIL basic_nwr: got %0d required %0d", got_wr.size(), m_wr.size());
        end
        foreach (m_wr[k]) begin
            checks++;
            if (k >= got_wr.size() || got_wr[k] !== m_wr[k]) begin
                errors++;
                $display("FAIL basic_wr%0d: got %h required %h", k,
                         (k < got_wr.size()) ? got_wr[k] : 64'hx, m_wr[k]);
            end
        end
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== exp_stat(m_st) || viol != 0) begin
            errors++;
            $display("FAIL basic_stat: got %b viol=%0d required %b viol=0",
                     {c_core_rst, c_load_done, c_load_err}, viol, exp_stat(m_st));
        end
    endtask

    task automatic test_resync();
        do_reset();
        send_glitch();
        add(8'h00); add(8'hFF); add(8'h5A);
        add(8'hA5); add(8'h01); add(8'h00);
        add(8'h04); add(8'h03); add(8'h02); add(8'h01);
        add_csum(8'h04);
        run_stream();
        checks++;
        if (got_wr.size() != m_wr.size()) begin
            errors++;
            $display("FAIL resync_nwr: got %0d required %0d", got_wr.size(), m_wr.size());
        end
        foreach (m_wr[k]) begin
            checks++;
            if (k >= got_wr.size() || got_wr[k] !== m_wr[k]) begin
                errors++;
                $display("FAIL resync_wr%0d: got %h required %h", k,
                         (k < got_wr.size()) ? got_wr[k] : 64'hx, m_wr[k]);
            end
        end
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== exp_stat(m_st) || viol != 0) begin
            errors++;
            $display("FAIL resync_stat: got %b viol=%0d required %b viol=0",
                     {c_core_rst, c_load_done, c_load_err}, viol, exp_stat(m_st));
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        add(8'hA5); add(8'h02); add(8'h00);
        add(8'h78); add(8'h56, 1'b1); add(8'h34); add(8'h12);
        add(8'hEF); add(8'hBE); add(8'hAD); add(8'hDE);
        run_stream();
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== 3'b101 || got_wr.size() != 0) begin
            errors++;
            $display("FAIL ferr_stat: got %b writes=%0d required 101 writes=0",
                     {c_core_rst, c_load_done, c_load_err}, got_wr.size());
        end
        add(8'hA5); add(8'h01); add(8'h00);
        add(8'h11); add(8'h22); add(8'h33); add(8'h44);
        add_csum(8'h44);
        run_stream();
        checks++;
        if (got_wr.size() != 1 || got_wr[0] !== {BASE, 32'h44332211}) begin
            errors++;
            $display("FAIL ferr_rewr: got n=%0d first=%h required n=1 %h", got_wr.size(),
                     (got_wr.size() > 0) ? got_wr[0] : 64'hx, {BASE, 32'h44332211});
        end
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== exp_stat(m_st) || viol != 0) begin
            errors++;
            $display("FAIL ferr_restat: got %b viol=%0d required %b viol=0",
                     {c_core_rst, c_load_done, c_load_err}, viol, exp_stat(m_st));
        end
    endtask

    task automatic test_len_limits();
        do_reset();
        add(8'hA5); add(8'h01); add(8'h10);
        add(8'h78); add(8'h56); add(8'h34); add(8'h12);
        run_stream();
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== exp_stat(m_st) || got_wr.size() != 0) begin
            errors++;
            $display("FAIL lenmax: got %b writes=%0d required %b writes=0",
                     {c_core_rst, c_load_done, c_load_err}, got_wr.size(), exp_stat(m_st));
        end
        add(8'hA5); add(8'h00); add(8'h00);
        add_csum(8'h00);
        run_stream();
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== exp_stat(m_st) || got_wr.size() != 0 || viol != 0) begin
            errors++;
            $display("FAIL len0: got %b writes=%0d viol=%0d required %b writes=0 viol=0",
                     {c_core_rst, c_load_done, c_load_err}, got_wr.size(), viol, exp_stat(m_st));
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        add(8'hA5); add(8'h02); add(8'h00);
        add(8'h78); add(8'h56); add(8'h34); add(8'h12); add(8'hEF); add(8'hBE);
        foreach (s_b[k]) send_byte(s_b[k], 1'b0);
        s_b.delete();
        s_bad.delete();
        repeat (2 * CLK_DIV) @(posedge clk);
        #2;
        checks++;
        if (got_wr.size() != 1 || got_wr[0] !== {BASE, 32'h12345678}) begin
            errors++;
            $display("FAIL midrst_pre: got n=%0d required n=1 %h", got_wr.size(), {BASE, 32'h12345678});
        end
        c_sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({wr_valid, wr_data, wr_addr, c_core_rst, c_load_done, c_load_err} !== {1'b0, 64'h0, 3'b100}) begin
            errors++;
            $display("FAIL midrst_vals: got v=%b d=%h a=%h s=%b required 0 0 0 100",
                     wr_valid, wr_data, wr_addr, {c_core_rst, c_load_done, c_load_err});
        end
        do_reset();
        add_img1();
        add_csum(8'h2A);
        run_stream();
        checks++;
        if (got_wr.size() != m_wr.size()) begin
            errors++;
            $display("FAIL midrst_nwr: got %0d required %0d", got_wr.size(), m_wr.size());
        end
        foreach (m_wr[k]) begin
            checks++;
            if (k >= got_wr.size() || got_wr[k] !== m_wr[k]) begin
                errors++;
                $display("FAIL midrst_wr%0d: got %h required %h", k,
                         (k < got_wr.size()) ? got_wr[k] : 64'hx, m_wr[k]);
            end
        end
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== exp_stat(m_st) || viol != 0) begin
            errors++;
            $display("FAIL midrst_stat: got %b viol=%0d required %b viol=0",
                     {c_core_rst, c_load_done, c_load_err}, viol, exp_stat(m_st));
        end
    endtask

`ifdef PMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        add_img1();
        add(8'h2A);
        run_stream();
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== 3'b010 || got_wr.size() != 2) begin
            errors++;
            $display("FAIL csum_good: got %b writes=%0d required 010 writes=2",
                     {c_core_rst, c_load_done, c_load_err}, got_wr.size());
        end
        add_img1();
        add(8'h2B);
        run_stream();
        checks++;
        if ({c_core_rst, c_load_done, c_load_err} !== 3'b101 || got_wr.size() != 4 || viol != 0) begin
            errors++;
            $display("FAIL csum_bad: got %b writes=%0d viol=%0d required 101 writes=4 viol=0",
                     {c_core_rst, c_load_done, c_load_err}, got_wr.size(), viol);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 8; it++) begin
            int nj, len;
            logic [7:0] x, v;
            nj  = $urandom_range(0, 3);
            len = $urandom_range(0, 4);
            x   = 8'h00;
            for (int j = 0; j < nj; j++) begin
                v = 8'($urandom);
                if (v == SYNC) v = 8'h5A;
                add(v, $urandom_range(0, 3) == 0);
            end
            add(SYNC);
            add(8'(len), $urandom_range(0, 11) == 0);
            add(8'h00);
            for (int d = 0; d < 4 * len; d++) begin
                v = 8'($urandom);
                x ^= v;
                add(v, $urandom_range(0, 24) == 0);
            end
            add_csum(($urandom_range(0, 3) == 0) ? (x ^ 8'h01) : x);
            run_stream();
            checks++;
            if ({c_core_rst, c_load_done, c_load_err} !== exp_stat(m_st)) begin
                errors++;
                $display("FAIL rand%0d_stat: got %b required %b", it,
                         {c_core_rst, c_load_done, c_load_err}, exp_stat(m_st));
            end
        end
        checks++;
        if (got_wr.size() != m_wr.size() || viol != 0) begin
            errors++;
            $display("FAIL rand_nwr: got %0d viol=%0d required %0d viol=0",
                     got_wr.size(), viol, m_wr.size());
        end
        foreach (m_wr[k]) begin
            checks++;
            if (k >= got_wr.size() || got_wr[k] !== m_wr[k]) begin
                errors++;
                $display("FAIL rand_wr%0d: got %h required %h", k,
                         (k < got_wr.size()) ? got_wr[k] : 64'hx, m_wr[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_frame_err();
        test_len_limits();
        test_mid_reset();
`ifdef PMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
